// File: rtl/frogger_pkg.sv
// Shared types and defaults for the frogger game-state controller.
package frogger_pkg;

  typedef enum logic [1:0] {
    StNewGame = 2'd0,
    StPlay    = 2'd1,
    StNewFrog = 2'd2,
    StOver    = 2'd3
  } game_state_e;

  localparam int unsigned DefaultFrogInit   = 3;
  localparam int unsigned DefaultPauseTicks = 120;
  localparam logic [3:0]  BCD_MAX           = 4'd9;

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter, 00..99 with silent wrap; clr has priority over inc.
module bcd2_counter
  import frogger_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  logic [3:0] dig0_q, dig0_d;
  logic [3:0] dig1_q, dig1_d;

  always_comb begin
    dig0_d = dig0_q;
    dig1_d = dig1_q;
    if (clr) begin
      dig0_d = 4'd0;
      dig1_d = 4'd0;
    end else if (inc) begin
      if (dig0_q == BCD_MAX) begin
        dig0_d = 4'd0;
        dig1_d = (dig1_q == BCD_MAX) ? 4'd0 : dig1_q + 4'd1;
      end else begin
        dig0_d = dig0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dig0_q <= 4'd0;
      dig1_q <= 4'd0;
    end else begin
      dig0_q <= dig0_d;
      dig1_q <= dig1_d;
    end
  end

  assign dig0 = dig0_q;
  assign dig1 = dig1_q;

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: game FSM, frog counter, pause timer and BCD score.
module frogger_game_ctrl
  import frogger_pkg::*;
#(
  parameter int unsigned FROG_INIT   = DefaultFrogInit,
  parameter int unsigned PAUSE_TICKS = DefaultPauseTicks
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       btn_start,
  input  logic       frog_home,
  input  logic       frog_hit,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] frog,
  output logic [1:0] state,
  output logic       graph_still
);

  localparam logic [1:0] FrogInit  = 2'(FROG_INIT);
  localparam logic [6:0] PauseLoad = 7'(PAUSE_TICKS - 1);

  game_state_e state_q;
  logic [1:0]  frog_q;
  logic [6:0]  timer_q;
  logic        score_clr;
  logic        score_inc;

  assign score_clr = (state_q == StNewGame) && btn_start;
  // A hit in the same cycle as a home arrival suppresses the point.
  assign score_inc = (state_q == StPlay) && frog_home && !frog_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StNewGame;
      frog_q  <= FrogInit;
      timer_q <= 7'd0;
    end else begin
      unique case (state_q)
        StNewGame: begin
          if (btn_start) begin
            state_q <= StPlay;
            frog_q  <= FrogInit;
          end
        end
        StPlay: begin
          if (frog_hit) begin
            timer_q <= PauseLoad;
            if (frog_q > 2'd1) begin
              frog_q  <= frog_q - 2'd1;
              state_q <= StNewFrog;
            end else begin
              frog_q  <= 2'd0;
              state_q <= StOver;
            end
          end
        end
        StNewFrog, StOver: begin
          if (tick) begin
            if (timer_q == 7'd0) begin
              state_q <= (state_q == StNewFrog) ? StPlay : StNewGame;
            end else begin
              timer_q <= timer_q - 7'd1;
            end
          end
        end
        default: state_q <= StNewGame;
      endcase
    end
  end

  bcd2_counter u_score (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (score_clr),
    .inc     (score_inc),
    .dig1    (dig1),
    .dig0    (dig0)
  );

  assign frog        = frog_q;
  assign state       = state_q;
  assign graph_still = (state_q != StPlay);

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Directed bench for frogger_game_ctrl with hand-computed expectations.
module tb_frogger_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick, btn_start, frog_home, frog_hit;
  logic [3:0] dig0, dig1;
  logic [1:0] frog, state;
  logic       graph_still;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  frogger_game_ctrl #(
    .FROG_INIT   (3),
    .PAUSE_TICKS (120)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .btn_start   (btn_start),
    .frog_home   (frog_home),
    .frog_hit    (frog_hit),
    .dig0        (dig0),
    .dig1        (dig1),
    .frog        (frog),
    .state       (state),
    .graph_still (graph_still)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic home_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      frog_home = 1'b1;
      step();
      frog_home = 1'b0;
      step();
    end
  endtask

  task automatic tick_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic hit_pulse();
    frog_hit = 1'b1;
    step();
    frog_hit = 1'b0;
  endtask

  task automatic check_score(input string tag, input int unsigned d1, input int unsigned d0);
    check({tag, "_dig1"}, dig1, d1);
    check({tag, "_dig0"}, dig0, d0);
  endtask

  initial begin
    reset_n = 1'b0;
    tick = 1'b0; btn_start = 1'b0; frog_home = 1'b0; frog_hit = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    check("rst_state", state, 0);
    check("rst_frog", frog, 3);
    check("rst_still", graph_still, 1);
    check_score("rst", 0, 0);

    // Start game.
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    check("start_state", state, 1);
    check("start_still", graph_still, 0);
    check("start_frog", frog, 3);

    // Start request ignored in PLAY.
    btn_start = 1'b1;
    step();
    btn_start = 1'b0;
    check("play_btn_state", state, 1);
    check_score("play_btn", 0, 0);

    home_pulses(12);
    check_score("score12", 1, 2);
    home_pulses(87);
    check_score("score99", 9, 9);
    home_pulses(1);
    check_score("wrap", 0, 0);
    home_pulses(5);
    check_score("score05", 0, 5);

    // Simultaneous home+hit, plus a tick on the NEWFROG entry edge.
    frog_home = 1'b1; frog_hit = 1'b1; tick = 1'b1;
    step();
    frog_home = 1'b0; frog_hit = 1'b0; tick = 1'b0;
    check("both_state", state, 2);
    check("both_frog", frog, 2);
    check("both_still", graph_still, 1);
    check_score("both", 0, 5);

    // Events ignored during NEWFROG.
    frog_home = 1'b1; btn_start = 1'b1;
    step();
    frog_home = 1'b0; btn_start = 1'b0;
    check_score("nf_home", 0, 5);
    check("nf_btn_state", state, 2);

    tick_pulses(119);
    check("nf_t119_state", state, 2);
    tick_pulses(1);
    check("nf_t120_state", state, 1);
    check("nf_t120_still", graph_still, 0);

    // Second hit -> NEWFROG with frog 1.
    hit_pulse();
    check("hit2_state", state, 2);
    check("hit2_frog", frog, 1);
    tick_pulses(120);
    check("hit2_resume", state, 1);

    // Third hit -> OVER.
    hit_pulse();
    check("over_state", state, 3);
    check("over_frog", frog, 0);
    check("over_still", graph_still, 1);
    tick_pulses(119);
    check("over_t119_state", state, 3);
    // Start held through OVER->NEWGAME launches a game on the first NEWGAME cycle.
    btn_start = 1'b1;
    step();
    check("over_btn_ignored", state, 3);
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("over_exit_state", state, 0);
    check("over_exit_frog", frog, 0);
    check_score("over_hold", 0, 5);
    step();
    btn_start = 1'b0;
    check("restart_state", state, 1);
    check("restart_frog", frog, 3);
    check_score("restart", 0, 0);

    // Asynchronous reset mid-play at score 37.
    home_pulses(37);
    check_score("score37", 3, 7);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_frog", frog, 3);
    check("arst_still", graph_still, 1);
    check_score("arst", 0, 0);
    step();
    reset_n = 1'b1;
    step();
    check("post_rst_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frogger_game_ctrl.md
# frogger_game_ctrl

Game-state controller that sits directly upstream of the text overlay. It produces the two BCD score digits and the remaining-frog count that the overlay renders as "Score:DD Frog:D". It also sequences the game through new-game, play, new-frog and game-over phases, using a refresh-tick timer for the pauses. Its collision and home-arrival inputs come from the graphics/motion stage, and its freeze output goes back to that stage.

## Interface
Parameters:
- FROG_INIT, 3: frogs at game start; legal range 1..3.
- PAUSE_TICKS, 120: refresh ticks per pause (2 s at 60 Hz); legal range 1..127.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle pulse per frame refresh
- btn_start  in  1  start request; synchronous, debounced level
- frog_home  in  1  one-cycle pulse: frog reached far bank
- frog_hit  in  1  one-cycle pulse: frog collided with a vehicle
- dig0  out  4  score units, BCD
- dig1  out  4  score tens, BCD
- frog  out  2  frogs remaining
- state  out  2  current game state; encoding comes from the package
- graph_still  out  1  freeze motion; high in every state except PLAY

One clock, clk. reset_n is asynchronous and active-low.

## Operation
- FSM states: NEWGAME=0, PLAY=1, NEWFROG=2, OVER=3.
- NEWGAME:
  - btn_start=1 → PLAY.
  - On the same edge, score clears to 00 and frog loads FROG_INIT.
- PLAY, frog_hit=1:
  - frog>1: frog decrements, go to NEWFROG.
  - frog==1: frog becomes 0, go to OVER.
- PLAY, frog_home=1 with frog_hit=0:
  - Score increments in BCD; dig0 9→0 carries into dig1.
  - 99→00 wraps silently.
- frog_hit and frog_home in the same cycle: the hit wins and the score is unchanged.
- NEWFROG: when the pause expires → PLAY. btn_start is ignored.
- OVER: when the pause expires → NEWGAME. Score and frog=0 are held for display until the next start.
- frog_home and frog_hit are ignored outside PLAY.
- btn_start is ignored outside NEWGAME.
- Pause timer:
  - 7-bit down counter, loaded with PAUSE_TICKS-1 on the edge that enters NEWFROG or OVER.
  - Decrements on each tick while in those states.
  - The pause expires on a tick that arrives while the counter is 0.
  - A tick coinciding with the entry edge is consumed by the load and does not count.
- graph_still = (state != PLAY), decoded from the state register.

## Timing
- All outputs are registered or decoded directly from registers. No combinational path from any input to any output.
- Latency: an event sampled at edge N is visible on the outputs after edge N.
- Pause length: exactly PAUSE_TICKS ticks after the entry edge. The transition happens on the edge that samples the final tick.
- Reset values: state=NEWGAME, dig0=0, dig1=0, frog=FROG_INIT, graph_still=1, timer=0.
- Reset asserted mid-pause or mid-play aborts immediately to the reset values. There is no deferred behaviour on release.
- btn_start held through OVER→NEWGAME starts a new game on the first NEWGAME cycle.

## Structure
- frogger_pkg holds:
  - state typedef and encodings
  - FROG_INIT and PAUSE_TICKS defaults
  - BCD_MAX = 4'd9
- Sub-module bcd2_counter:
  - Inputs: clr, inc.
  - Outputs: dig1, dig0.
  - Behaviour: wraps 99→00; clr has priority over inc.
  - Instantiated once for the score.
- The FSM, frog counter and pause timer live in the top module.

## Test plan
- Reset: assert reset_n=0 mid-PLAY with score 37 → dig1=0, dig0=0, frog=3, state=0, graph_still=1 without waiting for a clock edge.
- Scoring: start, then 12 frog_home pulses → dig1=1, dig0=2. Preload to 99, one more pulse → 00.
- Lose a frog: frog_hit with frog=3 → frog=2, state=NEWFROG, graph_still=1. After exactly 120 ticks → PLAY. Tick 119 alone does not change state.
- Game over: third hit → frog=0, state=OVER. After 120 ticks → NEWGAME with score held. btn_start → PLAY, score 00, frog 3.
- Simultaneous events: frog_home and frog_hit in the same cycle at score 05 → score stays 05 and frog decrements. frog_home during NEWFROG is ignored.
- Edge timing: a tick on the NEWFROG entry edge is not counted, so the pause ends 120 subsequent ticks later. btn_start during PLAY has no effect.
